// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock bursts in front of a single-port synchronous memory.
// One transaction at a time: IDLE arbitrates, GRANT drives the memory port, RDATA returns read data.
module mem_arbiter #(
  parameter int unsigned AW       = 8,
  parameter int unsigned DW       = 16,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          owner,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout
);

  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] CntMax = CW'(MAX_LOCK);
  localparam logic [CW-1:0] CntOne = CW'(1);

  typedef enum logic [1:0] {StIdle, StGrant, StRdata} state_e;

  state_e        st_q, st_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          held_q, held_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;

  logic req_last, req_other, keep, winner, in_grant, sel_we;

  assign req_last  = last_q ? req1 : req0;
  assign req_other = last_q ? req0 : req1;
  assign keep      = held_q && req_last && !((lock_cnt_q == CntMax) && req_other);
  assign in_grant  = (st_q == StGrant);
  assign sel_we    = sel_q ? we1 : we0;

  always_comb begin
    st_d       = st_q;
    sel_d      = sel_q;
    last_d     = last_q;
    held_d     = held_q;
    lock_cnt_d = lock_cnt_q;
    winner     = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (req0 || req1) begin
          if (keep) begin
            winner = last_q;
            // Saturate so the burst bound still applies after a long uncontested lock.
            if (lock_cnt_q != CntMax) lock_cnt_d = lock_cnt_q + CntOne;
          end else begin
            winner     = (req0 && req1) ? ~last_q : req1;
            lock_cnt_d = CntOne;
          end
          sel_d = winner;
          st_d  = StGrant;
        end
      end
      StGrant: begin
        last_d = sel_q;
        held_d = sel_q ? lock1 : lock0;
        st_d   = sel_we ? StIdle : StRdata;
      end
      StRdata: st_d = StIdle;
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q       <= StIdle;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      held_q     <= 1'b0;
      lock_cnt_q <= '0;
    end else begin
      st_q       <= st_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      held_q     <= held_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  // Outputs depend only on registered state (plus the selected port's fields in GRANT).
  always_comb begin
    gnt0     = in_grant && !sel_q;
    gnt1     = in_grant && sel_q;
    rvalid0  = (st_q == StRdata) && !sel_q;
    rvalid1  = (st_q == StRdata) && sel_q;
    rdata    = (st_q == StRdata) ? mem_dout : '0;
    owner    = last_q;
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (in_grant) begin
      mem_addr = sel_q ? addr1 : addr0;
      mem_din  = sel_q ? wdata1 : wdata0;
      mem_we   = sel_we;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a transaction-level arbitration model predicts
// every grant and read strobe into a scoreboard that an independent monitor drains.
module tb_mem_arbiter;
  localparam int MAX_LOCK = 4;

  typedef struct {
    int         cyc;
    bit         rv;
    bit         port;
    bit         we;
    logic [7:0] addr;
    logic [15:0] data;
  } ev_t;

  typedef struct {
    bit          we;
    bit          lock;
    logic [7:0]  addr;
    logic [15:0] data;
  } tx_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock0 = 1'b0, lock1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, owner, mem_we;
  logic [15:0] rdata, mem_din, mem_dout;
  logic [7:0]  mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(8), .DW(16), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .owner(owner), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  function automatic logic [15:0] init_val(input int i);
    if (i == 16) return 16'hBEEF;
    return (16'(i) * 16'h0101) ^ 16'h5A5A;
  endfunction

  // Memory attached to the DUT; read data registered, read-before-write.
  logic [15:0] mem [256];
  bit          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  int  checks = 0, errors = 0, cyc = 0;
  ev_t sb[$];
  tx_t dq0[$], dq1[$];
  bit  glog[$];
  bit  mon_en = 1'b0;
  int  rv_seen = 0;
  logic [15:0] last_rdata = '0;

  // Reference model state
  logic [15:0] mmem [256];
  int  m_idle_at = 0, m_cnt = 0, pend_cyc = 0;
  bit  m_last = 1'b1, m_held = 1'b0, exp_owner = 1'b1, pend_v = 1'b0, pend_port = 1'b0;
  bit  m_decided = 1'b0;

  // Driver state
  bit  act[2], g[2];
  tx_t cur[2];
  bit  rand_en = 1'b0, rst_on_grant = 1'b0;
  int  rst_hold = 2, rst_rate = 0;
  int  p_req[2], p_write = 50, p_lock[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic tx_t mk_tx(input bit we, input bit lock, input logic [7:0] a,
                                input logic [15:0] d);
    tx_t t;
    t.we = we; t.lock = lock; t.addr = a; t.data = d;
    return t;
  endfunction

  // Monitor: every strobe pops one scoreboard entry; quiet cycles check the memory port is idle.
  ev_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt0 || gnt1 || rvalid0 || rvalid1) begin
        if (gnt0 || gnt1) glog.push_back(gnt1);
        if (rvalid0 || rvalid1) begin
          rv_seen++;
          last_rdata = rdata;
        end
        if (sb.size() == 0) begin
          chk("unexpected_strobe", 64'({gnt0, gnt1, rvalid0, rvalid1}), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("event_cycle", 64'(cyc), 64'(e.cyc));
          if (e.rv)
            chk("read_data", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_din, rdata}),
                64'({2'b00, e.port == 1'b0, e.port == 1'b1, 1'b0, 8'h00, 16'h0000, e.data}));
          else
            chk("grant", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_din, rdata}),
                64'({e.port == 1'b0, e.port == 1'b1, 2'b00, e.we, e.addr, e.data, 16'h0000}));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk("missing_strobe", 64'({gnt0, gnt1, rvalid0, rvalid1}),
            64'({!e.rv && !e.port, !e.rv && e.port, e.rv && !e.port, e.rv && e.port}));
      end else begin
        chk("idle_outputs", 64'({mem_we, mem_addr, mem_din, rdata}), 64'(0));
      end
      chk("owner", 64'(owner), 64'(exp_owner));
    end
  end

  // Transaction-level arbitration rules applied to the inputs of cycle c.
  task automatic model_step(input int c);
    bit r[2], lk[2], wv[2], w;
    logic [7:0]  a[2];
    logic [15:0] d[2];
    m_decided = 1'b0;
    if (reset) begin
      m_idle_at = c + 1; m_last = 1'b1; m_held = 1'b0; m_cnt = 0;
      exp_owner = 1'b1; pend_v = 1'b0;
      while (sb.size() > 0 && sb[sb.size()-1].cyc > c) void'(sb.pop_back());
      return;
    end
    if (pend_v && pend_cyc == c) begin
      exp_owner = pend_port;
      pend_v = 1'b0;
    end
    if (c >= m_idle_at && (req0 || req1)) begin
      r[0] = req0; r[1] = req1; lk[0] = lock0; lk[1] = lock1; wv[0] = we0; wv[1] = we1;
      a[0] = addr0; a[1] = addr1; d[0] = wdata0; d[1] = wdata1;
      if (m_held && r[m_last] && !(m_cnt >= MAX_LOCK && r[!m_last])) begin
        w = m_last;
        m_cnt++;
      end else begin
        w = (r[0] && r[1]) ? !m_last : r[1];
        m_cnt = 1;
      end
      m_last = w; m_held = lk[w];
      sb.push_back('{cyc: c + 1, rv: 1'b0, port: w, we: wv[w], addr: a[w], data: d[w]});
      pend_v = 1'b1; pend_cyc = c + 1; pend_port = w;
      if (wv[w]) begin
        mmem[a[w]] = d[w];
        m_idle_at = c + 2;
      end else begin
        sb.push_back('{cyc: c + 2, rv: 1'b1, port: w, we: 1'b0, addr: a[w], data: mmem[a[w]]});
        m_idle_at = c + 3;
      end
      m_decided = 1'b1;
    end
  endtask

  task automatic drive();
    if (rst_hold > 0) begin
      reset = 1'b1;
      rst_hold--;
    end else if (rst_on_grant && m_decided) begin
      reset = 1'b1;
      rst_on_grant = 1'b0;
    end else begin
      reset = (rst_rate > 0) && ($urandom_range(rst_rate - 1) == 0);
    end
    for (int p = 0; p < 2; p++) begin
      if (g[p]) act[p] = 1'b0;
      if (!act[p]) begin
        if (p == 0 && dq0.size() > 0) begin
          cur[0] = dq0.pop_front(); act[0] = 1'b1;
        end else if (p == 1 && dq1.size() > 0) begin
          cur[1] = dq1.pop_front(); act[1] = 1'b1;
        end else if (rand_en && $urandom_range(99) < p_req[p]) begin
          cur[p] = mk_tx($urandom_range(99) < p_write, $urandom_range(99) < p_lock[p],
                         8'($urandom_range(15)), 16'($urandom));
          act[p] = 1'b1;
        end
      end
    end
    req0 = act[0]; we0 = cur[0].we; lock0 = cur[0].lock; addr0 = cur[0].addr; wdata0 = cur[0].data;
    req1 = act[1]; we1 = cur[1].we; lock1 = cur[1].lock; addr1 = cur[1].addr; wdata1 = cur[1].data;
  endtask

  task automatic step();
    @(negedge clk);
    g[0] = gnt0;
    g[1] = gnt1;
    @(posedge clk);
    model_step(cyc);
    cyc++;
    #1;
    drive();
  endtask

  task automatic drain(input int limit, input string name);
    int n = 0;
    while ((dq0.size() > 0 || dq1.size() > 0 || act[0] || act[1] || sb.size() > 0) && n < limit) begin
      step();
      n++;
    end
    chk({name, "_drained"}, 64'(dq0.size() + dq1.size() + int'(act[0]) + int'(act[1]) + sb.size()),
        64'(0));
    repeat (2) step();
  endtask

  task automatic fresh();
    rst_hold = 1;
    step();
    glog.delete();
  endtask

  function automatic logic [63:0] log_bits();
    logic [63:0] v = '0;
    foreach (glog[i]) v = {v[62:0], glog[i]};
    return v;
  endfunction

  int cfg_req0[3] = '{70, 100, 100};
  int cfg_req1[3] = '{70, 60, 90};
  int cfg_wr[3]   = '{50, 40, 70};
  int cfg_lk0[3]  = '{0, 20, 0};
  int cfg_lk1[3]  = '{0, 60, 100};
  int rv_before;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = init_val(i);
    act[0] = 1'b0; act[1] = 1'b0;
    cur[0] = mk_tx(1'b0, 1'b0, 8'h00, 16'h0000);
    cur[1] = cur[0];
    p_req[0] = 0; p_req[1] = 0; p_lock[0] = 0; p_lock[1] = 0;

    repeat (3) step();
    chk("reset_state", 64'({gnt0, gnt1, rvalid0, rvalid1, mem_we, mem_addr, mem_din, rdata, owner}),
        64'(1));
    mon_en = 1'b1;

    dq0.push_back(mk_tx(1'b0, 1'b0, 8'h10, 16'h0000));
    drain(40, "single_read");
    chk("single_read_data", 64'(last_rdata), 64'(16'hBEEF));

    dq1.push_back(mk_tx(1'b1, 1'b0, 8'h3F, 16'h1234));
    dq1.push_back(mk_tx(1'b0, 1'b0, 8'h3F, 16'h0000));
    drain(40, "write_readback");
    chk("readback_data", 64'(last_rdata), 64'(16'h1234));

    fresh();
    dq0.push_back(mk_tx(1'b1, 1'b0, 8'h01, 16'h1111));
    dq1.push_back(mk_tx(1'b1, 1'b0, 8'h02, 16'h2222));
    drain(40, "simul_writes");
    chk("simul_order", log_bits(), 64'b01);
    chk("simul_count", 64'(glog.size()), 64'(2));
    chk("simul_owner", 64'(owner), 64'(1));

    fresh();
    for (int i = 0; i < 4; i++) begin
      dq0.push_back(mk_tx(1'b0, 1'b0, 8'(i), 16'h0000));
      dq1.push_back(mk_tx(1'b0, 1'b0, 8'(i + 8), 16'h0000));
    end
    drain(80, "alt_reads");
    chk("alt_order", log_bits(), 64'b01010101);
    chk("alt_count", 64'(glog.size()), 64'(8));

    fresh();
    for (int i = 0; i < 2; i++) dq0.push_back(mk_tx(1'b1, 1'b0, 8'(i + 4), 16'(i)));
    for (int i = 0; i < 6; i++) dq1.push_back(mk_tx(1'b1, 1'b1, 8'(i + 8), 16'(i + 100)));
    drain(80, "lock_burst");
    chk("lock_order", log_bits(), 64'b01111011);
    chk("lock_count", 64'(glog.size()), 64'(8));

    dq0.push_back(mk_tx(1'b1, 1'b0, 8'h05, 16'h0505));
    drain(40, "pre_reset_write");
    rv_before = rv_seen;
    rst_on_grant = 1'b1;
    dq0.push_back(mk_tx(1'b0, 1'b0, 8'h10, 16'h0000));
    drain(40, "reset_read");
    chk("reset_read_no_rvalid", 64'(rv_seen - rv_before), 64'(0));
    chk("reset_read_owner", 64'(owner), 64'(1));

    rst_on_grant = 1'b1;
    dq1.push_back(mk_tx(1'b1, 1'b0, 8'h22, 16'hCAFE));
    drain(40, "reset_write");
    dq1.push_back(mk_tx(1'b0, 1'b0, 8'h22, 16'h0000));
    drain(40, "reset_write_readback");
    chk("reset_write_commit", 64'(last_rdata), 64'(16'hCAFE));

    rand_en = 1'b1;
    rst_rate = 150;
    for (int k = 0; k < 3; k++) begin
      p_req[0] = cfg_req0[k]; p_req[1] = cfg_req1[k];
      p_write = cfg_wr[k];
      p_lock[0] = cfg_lk0[k]; p_lock[1] = cfg_lk1[k];
      repeat (600) step();
    end
    rand_en = 1'b0;
    rst_rate = 0;
    drain(100, "random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
